wm_cycle_sequencer: RTL

- Washing-machine programme controller. Sequences one machine through fill, wash, drain, fill, rinse, drain and spin.
- Uses the wash/rinse/spin/cloth settings captured by the appliance controller.
- Drives actuator enables and reports phase and remaining time to the status outputs.
- Each appliance slot instantiates one copy, so machine 1 and machine 2 run independently.

---
 rtl/wm_cycle_sequencer.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/wm_cycle_sequencer.sv
// Washing-machine programme sequencer: fill, wash, drain, fill, rinse, drain, spin, done.
// Optional: define WM_EXTRA_RINSE_EN for the extra_rinse input and a second rinse pass.
module wm_cycle_sequencer #(
   parameter int TICK_DIV   = 10,
   parameter int FILL_BASE  = 2,
   parameter int DRAIN_TIME = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic       pause,
   input  logic       abort,
   input  logic [4:0] wash,
   input  logic [4:0] rinse,
   input  logic [4:0] spin,
   input  logic [4:0] cloth,
`ifdef WM_EXTRA_RINSE_EN
   input  logic       extra_rinse,
`endif
   output logic [3:0] phase,
   output logic [4:0] remaining,
   output logic       busy,
   output logic       done,
   output logic       aborted,
   output logic       water_valve,
   output logic       drain_pump,
   output logic       motor_on,
   output logic       motor_fast,
   output logic       door_lock
);
   typedef enum logic [3:0] {
      IDLE = 4'd0, FILL_W = 4'd1, WASH = 4'd2, DRAIN_W = 4'd3, FILL_R = 4'd4,
      RINSE = 4'd5, DRAIN_R = 4'd6, SPIN = 4'd7, DONE = 4'd8
   } phase_e;

   localparam int            PW          = $clog2(TICK_DIV);
   localparam logic [PW-1:0] PRESC_MAX   = PW'(TICK_DIV - 1);
   localparam logic [4:0]    DRAIN_UNITS = 5'(DRAIN_TIME);
   localparam logic [5:0]    FILL_BASE_6 = 6'(FILL_BASE);

   function automatic logic [4:0] sat_fill(input logic [4:0] c);
      logic [5:0] sum;
      sum = FILL_BASE_6 + {1'b0, c};
      return sum[5] ? 5'd31 : sum[4:0];
   endfunction

   // A timed phase whose latched duration is zero is replaced by its successor.
   function automatic phase_e skip_zero(input phase_e p, input logic [4:0] w, input logic [4:0] r,
                                        input logic [4:0] s);
      phase_e q;
      q = p;
      if (p == WASH && w == 5'd0) q = DRAIN_W;
      if (p == RINSE && r == 5'd0) q = DRAIN_R;
      if (p == SPIN && s == 5'd0) q = DONE;
      return q;
   endfunction

   function automatic logic [4:0] dur_of(input phase_e p, input logic [4:0] f, input logic [4:0] w,
                                         input logic [4:0] r, input logic [4:0] s);
      logic [4:0] d;
      case (p)
         FILL_W, FILL_R:   d = f;
         WASH:             d = w;
         RINSE:            d = r;
         DRAIN_W, DRAIN_R: d = DRAIN_UNITS;
         SPIN:             d = s;
         default:          d = 5'd0;
      endcase
      return d;
   endfunction

   phase_e        phase_q, phase_d, nxt;
   logic [4:0]    remaining_q, remaining_d;
   logic [PW-1:0] presc_q, presc_d;
   logic          paused_q, paused_d;
   logic          abort_pend_q, abort_pend_d;
   logic          aborted_q, aborted_d;
   logic [4:0]    wash_q, wash_d, rinse_q, rinse_d, spin_q, spin_d, fill_q, fill_d;
   logic          enter, run;
`ifdef WM_EXTRA_RINSE_EN
   logic          extra_q, extra_d, pass_q, pass_d;
`endif

   always_comb begin
      phase_d      = phase_q;
      remaining_d  = remaining_q;
      presc_d      = presc_q;
      paused_d     = pause;
      abort_pend_d = abort_pend_q;
      aborted_d    = 1'b0;
      wash_d       = wash_q;
      rinse_d      = rinse_q;
      spin_d       = spin_q;
      fill_d       = fill_q;
      enter        = 1'b0;
      nxt          = phase_q;
`ifdef WM_EXTRA_RINSE_EN
      extra_d      = extra_q;
      pass_d       = pass_q;
`endif
      case (phase_q)
         IDLE: begin
            abort_pend_d = 1'b0;
`ifdef WM_EXTRA_RINSE_EN
            pass_d = 1'b0;
`endif
            if (start) begin
               wash_d  = wash;
               rinse_d = rinse;
               spin_d  = spin;
               fill_d  = sat_fill(cloth);
`ifdef WM_EXTRA_RINSE_EN
               extra_d = extra_rinse;
`endif
               nxt   = FILL_W;
               enter = 1'b1;
            end
         end
         DONE: begin
            nxt   = IDLE;
            enter = 1'b1;
         end
         default: begin
            // Abort outranks both pause and a tick-driven advance.
            if (abort) begin
               enter = 1'b1;
               if (phase_q == SPIN) begin
                  nxt          = IDLE;
                  aborted_d    = 1'b1;
                  abort_pend_d = 1'b0;
               end else begin
                  nxt          = DRAIN_R;
                  abort_pend_d = 1'b1;
               end
            end else if (!paused_q) begin
               if (presc_q != PRESC_MAX) begin
                  presc_d = presc_q + PW'(1);
               end else if (remaining_q > 5'd1) begin
                  remaining_d = remaining_q - 5'd1;
                  presc_d     = '0;
               end else begin
                  enter = 1'b1;
                  case (phase_q)
                     FILL_W:  nxt = WASH;
                     WASH:    nxt = DRAIN_W;
                     DRAIN_W: nxt = FILL_R;
                     FILL_R:  nxt = RINSE;
                     RINSE:   nxt = DRAIN_R;
                     DRAIN_R: begin
                        if (abort_pend_q) begin
                           nxt          = IDLE;
                           aborted_d    = 1'b1;
                           abort_pend_d = 1'b0;
`ifdef WM_EXTRA_RINSE_EN
                        end else if (extra_q && !pass_q) begin
                           nxt    = FILL_R;
                           pass_d = 1'b1;
`endif
                        end else begin
                           nxt = SPIN;
                        end
                     end
                     default: nxt = DONE;
                  endcase
               end
            end
         end
      endcase
      if (enter) begin
         phase_d     = skip_zero(nxt, wash_d, rinse_d, spin_d);
         remaining_d = dur_of(phase_d, fill_d, wash_d, rinse_d, spin_d);
         presc_d     = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         phase_q      <= IDLE;
         remaining_q  <= '0;
         presc_q      <= '0;
         paused_q     <= 1'b0;
         abort_pend_q <= 1'b0;
         aborted_q    <= 1'b0;
         wash_q       <= '0;
         rinse_q      <= '0;
         spin_q       <= '0;
         fill_q       <= '0;
`ifdef WM_EXTRA_RINSE_EN
         extra_q      <= 1'b0;
         pass_q       <= 1'b0;
`endif
      end else begin
         phase_q      <= phase_d;
         remaining_q  <= remaining_d;
         presc_q      <= presc_d;
         paused_q     <= paused_d;
         abort_pend_q <= abort_pend_d;
         aborted_q    <= aborted_d;
         wash_q       <= wash_d;
         rinse_q      <= rinse_d;
         spin_q       <= spin_d;
         fill_q       <= fill_d;
`ifdef WM_EXTRA_RINSE_EN
         extra_q      <= extra_d;
         pass_q       <= pass_d;
`endif
      end
   end

   // Actuators drop while paused, but the door stays locked for the whole programme.
   always_comb begin
      run         = !paused_q;
      phase       = phase_q;
      remaining   = remaining_q;
      busy        = (phase_q != IDLE);
      done        = (phase_q == DONE);
      aborted     = aborted_q;
      water_valve = run && (phase_q == FILL_W || phase_q == FILL_R);
      drain_pump  = run && (phase_q == DRAIN_W || phase_q == DRAIN_R || phase_q == SPIN);
      motor_on    = run && (phase_q == WASH || phase_q == RINSE || phase_q == SPIN);
      motor_fast  = run && (phase_q == SPIN);
      door_lock   = (phase_q != IDLE) && (phase_q != DONE);
   end
endmodule
